psum_accumulator: RTL and testbench

//  Channel accumulator behind the systolic array. It sums LANES signed partial

---
 rtl/psum_accumulator_pkg.sv | 60 ++++++
 rtl/psum_accumulator_if.sv | 34 +++
 rtl/psum_accumulator_requant.sv | 14 +
 rtl/psum_accumulator.sv | 169 ++++++++++++++++
 tb/tb_psum_accumulator.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_accumulator_pkg.sv
// psum_accumulator shared types, sizes and arithmetic helpers.
// Widths are fixed here so every file agrees on the lane layout.
package psum_accumulator_pkg;

  localparam int LANES  = 4;
  localparam int PSUM_W = 16;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;
  localparam int DEPTH  = 1024;
  localparam int CH_W   = 6;
  localparam int AW     = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    LAST
  } state_t;

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [OUT_W-1:0]  out_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam out_t OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam out_t OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  function automatic acc_t sat_acc(
    input acc_t  a,
    input psum_t b
  );
    logic signed [ACC_W:0] s;
    s = $signed({a[ACC_W-1], a})
      + $signed({{(ACC_W+1-PSUM_W){b[PSUM_W-1]}}, b});
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  // One guard bit keeps the rounding add from wrapping.
  function automatic out_t requant(
    input acc_t       sum,
    input logic [4:0] shift,
    input logic       relu
  );
    logic signed [ACC_W:0] t;
    logic [ACC_W:0]        rnd;
    rnd = '0;
    if (shift != 5'd0)
      rnd = {{ACC_W{1'b0}}, 1'b1} << (shift - 5'd1);
    t = ($signed({sum[ACC_W-1], sum}) + $signed(rnd))
      >>> shift;
    if (relu && t[ACC_W])
      t = '0;
    if (t[ACC_W:OUT_W-1] != {(ACC_W-OUT_W+2){t[ACC_W]}})
      return t[ACC_W] ? OUT_MIN : OUT_MAX;
    return t[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Stream bundle for psum_accumulator: psum input and result output.
// master drives psums and consumes results; slave is the accumulator.
interface psum_accumulator_if;
  import psum_accumulator_pkg::*;

  logic                     psum_valid;
  logic                     psum_ready;
  logic [LANES*PSUM_W-1:0]  psum_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*OUT_W-1:0]   out_data;
  logic                     out_last;

  modport master (
    output psum_valid,
    output psum_data,
    output out_ready,
    input  psum_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  psum_valid,
    input  psum_data,
    input  out_ready,
    output psum_ready,
    output out_valid,
    output out_data,
    output out_last
  );

endinterface

// File: rtl/psum_accumulator_requant.sv
// Per-lane requantizer: round, arithmetic shift, optional ReLU,
// then saturate to the output width.
module psum_accumulator_requant
  import psum_accumulator_pkg::*;
(
  input  acc_t       sum,
  input  logic [4:0] shift,
  input  logic       relu,
  output out_t       q
);

  assign q = requant(sum, shift, relu);

endmodule

// File: rtl/psum_accumulator.sv
// Channel accumulator: sums lane psums per pixel across input
// channels, requantizes on the last channel and streams results out.
module psum_accumulator
  import psum_accumulator_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW:0]       cfg_ofmap_size,
  input  logic [CH_W-1:0]   cfg_ifmap_ch,
  input  logic [4:0]        cfg_shift,
  input  logic              cfg_relu,
  output logic              busy,
  output logic              done,
  psum_accumulator_if.slave bus
);

  localparam int BW = LANES * ACC_W;
  localparam int OW = LANES * OUT_W;

  state_t          state, state_n;
  logic [AW:0]     size_q;
  logic [CH_W-1:0] nch_q;
  logic [4:0]      shift_q;
  logic            relu_q;
  logic [AW-1:0]   pix, pix_n;
  logic [CH_W-1:0] ch, ch_n;
  logic            done_n;
  logic            ov, ov_n;
  logic            ol, ol_n;
  logic [OW-1:0]   od, od_n;
  logic            cfg_ld;

  logic [BW-1:0]   mem [DEPTH];
  logic [BW-1:0]   rd;
  logic [BW-1:0]   sum;
  logic [OW-1:0]   rq;
  logic            in_hs;
  logic            out_hs;
  logic            last_pix;
  logic            we;

  assign rd       = mem[pix];
  assign in_hs    = bus.psum_valid && bus.psum_ready;
  assign out_hs   = ov && bus.out_ready;
  assign last_pix = ({1'b0, pix} == size_q - 1'b1);
  assign we       = (state == ACC) && in_hs;

  // Channel 0 starts from zero, so stale buffer data never leaks.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    acc_t base;
    assign base = (ch == '0) ? '0 : rd[i*ACC_W +: ACC_W];
    assign sum[i*ACC_W +: ACC_W] =
      sat_acc(base, bus.psum_data[i*PSUM_W +: PSUM_W]);
    psum_accumulator_requant u_rq (
      .sum   (sum[i*ACC_W +: ACC_W]),
      .shift (shift_q),
      .relu  (relu_q),
      .q     (rq[i*OUT_W +: OUT_W])
    );
  end

  // A held final result blocks intake; else refill while draining.
  always_comb begin
    bus.psum_ready = 1'b0;
    unique case (1'b1)
      state == ACC:  bus.psum_ready = 1'b1;
      state == LAST: bus.psum_ready =
        !ov || (bus.out_ready && !ol);
      default:       bus.psum_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    pix_n   = pix;
    ch_n    = ch;
    done_n  = 1'b0;
    ov_n    = ov;
    ol_n    = ol;
    od_n    = od;
    cfg_ld  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ofmap_size == '0 || cfg_ifmap_ch == '0) begin
            done_n = 1'b1;
          end else begin
            cfg_ld  = 1'b1;
            pix_n   = '0;
            ch_n    = '0;
            state_n = (cfg_ifmap_ch == CH_W'(1)) ? LAST : ACC;
          end
        end
      end
      ACC: begin
        if (in_hs) begin
          if (last_pix) begin
            pix_n = '0;
            ch_n  = ch + 1'b1;
            if (ch == nch_q - CH_W'(2))
              state_n = LAST;
          end else begin
            pix_n = pix + 1'b1;
          end
        end
      end
      LAST: begin
        if (out_hs) begin
          ov_n = 1'b0;
          ol_n = 1'b0;
          if (ol) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        if (in_hs) begin
          ov_n = 1'b1;
          ol_n = last_pix;
          od_n = rq;
          if (!last_pix)
            pix_n = pix + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pix     <= '0;
      ch      <= '0;
      done    <= 1'b0;
      ov      <= 1'b0;
      ol      <= 1'b0;
      od      <= '0;
      size_q  <= '0;
      nch_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      state <= state_n;
      pix   <= pix_n;
      ch    <= ch_n;
      done  <= done_n;
      ov    <= ov_n;
      ol    <= ol_n;
      od    <= od_n;
      if (cfg_ld) begin
        size_q  <= cfg_ofmap_size;
        nch_q   <= cfg_ifmap_ch;
        shift_q <= cfg_shift;
        relu_q  <= cfg_relu;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[pix] <= sum;
  end

  assign busy         = (state != IDLE);
  assign bus.out_valid = ov;
  assign bus.out_last  = ol;
  assign bus.out_data  = od;

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: a behavioural model fills
// the expected queue, output handshakes pop and compare.
module tb_psum_accumulator;
  import psum_accumulator_pkg::*;

  localparam int EW = LANES * OUT_W + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW:0]     cfg_ofmap_size;
  logic [CH_W-1:0] cfg_ifmap_ch;
  logic [4:0]      cfg_shift;
  logic            cfg_relu;
  logic            busy;
  logic            done;

  int tests = 0;
  int fails = 0;
  int bv[$];
  logic [EW-1:0] exp_q[$];

  psum_accumulator_if bus();

  psum_accumulator dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_ofmap_size (cfg_ofmap_size),
    .cfg_ifmap_ch   (cfg_ifmap_ch),
    .cfg_shift      (cfg_shift),
    .cfg_relu       (cfg_relu),
    .busy           (busy),
    .done           (done),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int model_rq(int s, int sh, bit relu);
    int r;
    r = s + ((sh != 0) ? (1 << (sh - 1)) : 0);
    r = r >>> sh;
    if (relu && r < 0) r = 0;
    return clampi(r, -128, 127);
  endfunction

  function automatic void build_expected(
    int size, int nch, int sh, bit relu
  );
    logic [EW-1:0] e;
    int acc;
    exp_q.delete();
    for (int p = 0; p < size; p++) begin
      e = '0;
      for (int l = 0; l < LANES; l++) begin
        acc = 0;
        for (int c = 0; c < nch; c++)
          acc = clampi(acc + bv[(c*size+p)*LANES+l],
                       -(1 << 23), (1 << 23) - 1);
        e[l*OUT_W +: OUT_W] = OUT_W'(model_rq(acc, sh, relu));
      end
      e[EW-1] = (p == size - 1);
      exp_q.push_back(e);
    end
  endfunction

  function automatic void fill_rand(int n, int span);
    bv.delete();
    for (int i = 0; i < n * LANES; i++)
      bv.push_back(int'($urandom_range(0, 2*span)) - span);
  endfunction

  function automatic void fill_const(int n, int v);
    bv.delete();
    for (int i = 0; i < n * LANES; i++)
      bv.push_back(v);
  endfunction

  task automatic run_pass(
    input string nm, input int size, input int nch,
    input int sh, input bit relu, input bit bp, input bit bump
  );
    int beat, total, cyc;
    bit last_seen, stalled;
    logic [EW:0]   held;
    logic [EW-1:0] got, ex;
    total = size * nch;
    build_expected(size, nch, sh, relu);
    @(negedge clk);
    cfg_ofmap_size = (AW+1)'(size);
    cfg_ifmap_ch   = CH_W'(nch);
    cfg_shift      = 5'(sh);
    cfg_relu       = relu;
    start          = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    beat      = 0;
    last_seen = 1'b0;
    stalled   = 1'b0;
    held      = '0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      bus.out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      start = bump && (cyc == 2);
      if (start) begin
        cfg_ofmap_size = (AW+1)'(1);
        cfg_ifmap_ch   = CH_W'(1);
      end
      bus.psum_valid = (beat < total);
      bus.psum_data  = '0;
      if (beat < total)
        for (int l = 0; l < LANES; l++)
          bus.psum_data[l*PSUM_W +: PSUM_W] =
            PSUM_W'(bv[beat*LANES+l]);
      #1;
      tests++;
      if (done !== last_seen)
        $display("FAIL %s done: got %b want %b",
                 nm, done, last_seen);
      if (done !== last_seen) fails++;
      if (last_seen) begin
        tests++;
        if (busy !== 1'b0) begin
          $display("FAIL %s busy_end: got %b want 0", nm, busy);
          fails++;
        end
        break;
      end
      if (stalled) begin
        tests++;
        got = {bus.out_last, bus.out_data};
        if ({bus.out_valid, got} !== held) begin
          $display("FAIL %s stall_hold: got %h want %h",
                   nm, {bus.out_valid, got}, held);
          fails++;
        end
      end
      if (bp && beat >= (nch - 1) * size && beat < total) begin
        tests++;
        if (bus.psum_ready !== (!bus.out_valid || bus.out_ready)) begin
          $display("FAIL %s psum_ready: got %b want %b", nm,
                   bus.psum_ready, !bus.out_valid || bus.out_ready);
          fails++;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        got = {bus.out_last, bus.out_data};
        tests++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s extra_beat: got %h want none", nm, got);
          fails++;
        end else begin
          ex = exp_q.pop_front();
          if (got !== ex) begin
            $display("FAIL %s out: got %h want %h", nm, got, ex);
            fails++;
          end
        end
        if (bus.out_last) last_seen = 1'b1;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = {bus.out_valid, bus.out_last, bus.out_data};
      if (bus.psum_valid && bus.psum_ready) beat++;
      @(negedge clk);
    end
    bus.psum_valid = 1'b0;
    bus.out_ready  = 1'b1;
    start          = 1'b0;
    tests++;
    if (cyc >= 3000) begin
      $display("FAIL %s timeout: got %0d cycles want <3000", nm, cyc);
      fails++;
    end
    tests++;
    if (exp_q.size() != 0 || beat != total) begin
      $display("FAIL %s count: got left=%0d beats=%0d want 0/%0d",
               nm, exp_q.size(), beat, total);
      fails++;
    end
    @(negedge clk);
    #1;
    tests++;
    if (done !== 1'b0) begin
      $display("FAIL %s done_pulse: got %b want 0", nm, done);
      fails++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({busy, done, bus.psum_ready} !== 3'b000) begin
      $display("FAIL reset_ctl: got %b want 000",
               {busy, done, bus.psum_ready});
      fails++;
    end
    tests++;
    if ({bus.out_valid, bus.out_last} !== 2'b00) begin
      $display("FAIL reset_out: got %b want 00",
               {bus.out_valid, bus.out_last});
      fails++;
    end
    tests++;
    if (bus.out_data !== '0) begin
      $display("FAIL reset_data: got %h want 0", bus.out_data);
      fails++;
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bv.delete();
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < 4; p++)
        for (int l = 0; l < LANES; l++)
          bv.push_back(p + 1);
    run_pass("basic", 4, 3, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_requant();
    fill_const(1, -300);
    run_pass("rq_neg", 1, 1, 2, 1'b0, 1'b0, 1'b0);
    fill_const(1, -300);
    run_pass("rq_relu", 1, 1, 2, 1'b1, 1'b0, 1'b0);
    fill_rand(6, 4000);
    run_pass("rq_rand", 3, 2, 4, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    fill_const(2, 32767);
    run_pass("sat_pos", 1, 2, 0, 1'b0, 1'b0, 1'b0);
    fill_const(2, -32768);
    run_pass("sat_neg", 1, 2, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    fill_rand(24, 30000);
    run_pass("bp", 8, 3, 5, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    bv.delete();
    for (int c = 0; c < 4; c++)
      for (int l = 0; l < LANES; l++)
        bv.push_back(10 * (c + 1));
    run_pass("b2b", 1, 4, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    @(negedge clk);
    cfg_ofmap_size = (AW+1)'(4);
    cfg_ifmap_ch   = CH_W'(3);
    cfg_shift      = 5'd0;
    cfg_relu       = 1'b0;
    start          = 1'b1;
    @(negedge clk);
    start          = 1'b0;
    bus.psum_valid = 1'b1;
    bus.psum_data  = {LANES{16'sd9000}};
    repeat (5) @(negedge clk);
    bus.psum_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, bus.psum_ready, bus.out_valid} !== 3'b000) begin
      $display("FAIL abort_rst: got %b want 000",
               {busy, bus.psum_ready, bus.out_valid});
      fails++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      tests++;
      if ({done, busy, bus.out_valid} !== 3'b000) begin
        $display("FAIL abort_quiet: got %b want 000",
                 {done, busy, bus.out_valid});
        fails++;
      end
    end
    fill_const(4, 5);
    run_pass("after_abort", 2, 2, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    fill_rand(6, 1000);
    run_pass("busy_start", 3, 2, 1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_size_zero();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cfg_ofmap_size = (k == 0) ? '0 : (AW+1)'(2);
      cfg_ifmap_ch   = (k == 0) ? CH_W'(2) : '0;
      start          = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      tests++;
      if ({done, busy} !== 2'b10) begin
        $display("FAIL zero_cfg%0d: got %b want 10",
                 k, {done, busy});
        fails++;
      end
      @(negedge clk);
      #1;
      tests++;
      if ({done, busy, bus.psum_ready} !== 3'b000) begin
        $display("FAIL zero_after%0d: got %b want 000",
                 k, {done, busy, bus.psum_ready});
        fails++;
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    cfg_ofmap_size = '0;
    cfg_ifmap_ch   = '0;
    cfg_shift      = '0;
    cfg_relu       = 1'b0;
    bus.psum_valid = 1'b0;
    bus.psum_data  = '0;
    bus.out_ready  = 1'b0;
    test_reset();
    bus.out_ready = 1'b1;
    test_basic();
    test_requant();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_start_ignored();
    test_size_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
